backward_delta: RTL and testbench

//  Stage directly downstream of the backward multiply-accumulate. Consumes the NC accumulated

---
 rtl/backward_delta_pkg.sv | 34 +++
 rtl/delta_lane.sv | 61 ++++++
 rtl/backward_delta.sv | 144 ++++++++++++++
 tb/tb_backward_delta.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/backward_delta_pkg.sv
// ============================================================================
//  Module      : backward_delta_pkg
//  Description : Shared helpers for the backward delta stage: accumulator lane
//                width, per-lane saturation bounds and lane slice offsets.
//                The forward activation stage reuses the same helpers.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package backward_delta_pkg;

    // Accumulator lane width for a fan-in of nn on wf-bit operands.
    function automatic int wa_width(input int nn, input int wf);
        return $clog2(nn) + wf;
    endfunction

    // Largest value representable on a wf-bit signed lane.
    function automatic int sat_max(input int wf);
        return (1 << (wf - 1)) - 1;
    endfunction

    // Smallest value representable on a wf-bit signed lane.
    function automatic int sat_min(input int wf);
        return -(1 << (wf - 1));
    endfunction

    // Bit offset of lane k in a vector of w-bit lanes.
    function automatic int lane_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/delta_lane.sv
// ============================================================================
//  Module      : delta_lane
//  Description : Combinational per-lane datapath: arithmetic right shift of
//                the accumulated error, saturation to WF bits, and the ReLU
//                derivative mask taken from the forward activation.
//  Ports       : i_accum    WA-bit signed accumulated error
//                i_act      WF-bit signed forward activation
//                o_sat      WF-bit saturated (unmasked) delta
//                o_mask     1 when the activation is strictly positive
//                o_sat_flag 1 when saturation changed the shifted value
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module delta_lane
    import backward_delta_pkg::*;
#(
    parameter int WA    = 8,
    parameter int WF    = 5,
    parameter int SHIFT = 0
) (
    input  logic [WA-1:0] i_accum,
    input  logic [WF-1:0] i_act,
    output logic [WF-1:0] o_sat,
    output logic          o_mask,
    output logic          o_sat_flag
);

    // Bounds held at the full accumulator width so the clamp compares like
    // with like; WA >= WF always holds, so both bounds are representable.
    localparam logic signed [WA-1:0] C_MAX = WA'(sat_max(WF));
    localparam logic signed [WA-1:0] C_MIN = WA'(sat_min(WF));

    logic signed [WA-1:0] w_shifted;
    logic signed [WA-1:0] w_clamped;

    // Arithmetic shift never overflows: the result magnitude only shrinks.
    assign w_shifted = $signed(i_accum) >>> SHIFT;

    always_comb begin
        if (w_shifted > C_MAX) begin
            w_clamped = C_MAX;
        end else if (w_shifted < C_MIN) begin
            w_clamped = C_MIN;
        end else begin
            w_clamped = w_shifted;
        end
    end

    // w_clamped is always within WF-bit range, so it equals the sign
    // extension of its low WF bits; comparing it to the shifted value is the
    // saturation test.
    assign o_sat      = w_clamped[WF-1:0];
    assign o_sat_flag = (w_clamped != w_shifted);

    // ReLU derivative: positive means sign clear and not zero.
    assign o_mask     = ~i_act[WF-1] & (|i_act);

endmodule

`default_nettype wire

// File: rtl/backward_delta.sv
// ============================================================================
//  Module      : backward_delta
//  Description : Backward delta stage. Joins the accumulated error vector with
//                the forward activation vector, shifts and saturates each lane
//                to WF bits, masks by the ReLU derivative, and presents the
//                previous layer's delta vector. Two registered stages with
//                elastic valid/ready on every port.
//  Ports       : iCLK / iRST                clock, synchronous active-high reset
//                iValid/oReady/iData_AM_Accum2  accum vector in (NC x WA)
//                iValid/oReady/iData_AM_Activ   activation vector in (NC x WF)
//                oValid/iReady/oData_BM_Delta1  delta vector out (NC x WF)
//                oSat                       sticky saturation flag
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module backward_delta
    import backward_delta_pkg::*;
#(
    parameter int    NN    = 7,
    parameter int    NC    = 11,
    parameter int    WF    = 5,
    parameter int    SHIFT = 0,
    parameter string BURST = "yes",
    localparam int   WA    = wa_width(NN, WF)
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iValid_AM_Accum2,
    output logic             oReady_AM_Accum2,
    input  logic [NC*WA-1:0] iData_AM_Accum2,
    input  logic             iValid_AM_Activ,
    output logic             oReady_AM_Activ,
    input  logic [NC*WF-1:0] iData_AM_Activ,
    output logic             oValid_BM_Delta1,
    input  logic             iReady_BM_Delta1,
    output logic [NC*WF-1:0] oData_BM_Delta1,
    output logic             oSat
);

    localparam bit C_BURST = (BURST == "yes");

    // ------------------------------------------------------------------
    // Per-lane combinational datapath
    // ------------------------------------------------------------------
    logic [NC*WF-1:0] w_lane_sat;
    logic [NC-1:0]    w_lane_mask;
    logic [NC-1:0]    w_lane_flag;

    for (genvar k = 0; k < NC; k++) begin : g_lane
        delta_lane #(
            .WA    (WA),
            .WF    (WF),
            .SHIFT (SHIFT)
        ) u_lane (
            .i_accum    (iData_AM_Accum2[lane_lo(k, WA) +: WA]),
            .i_act      (iData_AM_Activ[lane_lo(k, WF) +: WF]),
            .o_sat      (w_lane_sat[lane_lo(k, WF) +: WF]),
            .o_mask     (w_lane_mask[k]),
            .o_sat_flag (w_lane_flag[k])
        );
    end

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic             s1_vld_q,  s1_vld_d;
    logic [NC*WF-1:0] s1_sat_q,  s1_sat_d;
    logic [NC-1:0]    s1_mask_q, s1_mask_d;
    logic             s1_any_q,  s1_any_d;
    logic             s2_vld_q,  s2_vld_d;
    logic [NC*WF-1:0] s2_data_q, s2_data_d;
    logic             sat_q,     sat_d;

    logic             w_s1_can_load;
    logic             w_s2_can_load;
    logic             w_join;
    logic             w_s1_move;
    logic [NC*WF-1:0] w_masked;

    always_comb begin
        w_s2_can_load = ~s2_vld_q | iReady_BM_Delta1;
        // Non-burst mode admits a new vector only when the whole pipe is
        // empty, so exactly one vector is ever in flight.
        if (C_BURST) begin
            w_s1_can_load = ~s1_vld_q | w_s2_can_load;
        end else begin
            w_s1_can_load = ~s1_vld_q & ~s2_vld_q;
        end
        w_join    = iValid_AM_Accum2 & iValid_AM_Activ & w_s1_can_load;
        w_s1_move = s1_vld_q & w_s2_can_load;
    end

    always_comb begin
        w_masked = '0;
        for (int k = 0; k < NC; k++) begin
            if (s1_mask_q[k]) begin
                w_masked[k*WF +: WF] = s1_sat_q[k*WF +: WF];
            end
        end
    end

    always_comb begin
        s1_vld_d  = w_join | (s1_vld_q & ~w_s1_move);
        s1_sat_d  = w_join ? w_lane_sat   : s1_sat_q;
        s1_mask_d = w_join ? w_lane_mask  : s1_mask_q;
        s1_any_d  = w_join ? |w_lane_flag : s1_any_q;

        s2_vld_d  = w_s1_move | (s2_vld_q & ~iReady_BM_Delta1);
        s2_data_d = w_s1_move ? w_masked : s2_data_q;

        sat_d     = sat_q | (w_s1_move & s1_any_q);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            s1_vld_q  <= 1'b0;
            s1_sat_q  <= '0;
            s1_mask_q <= '0;
            s1_any_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s2_data_q <= '0;
            sat_q     <= 1'b0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_sat_q  <= s1_sat_d;
            s1_mask_q <= s1_mask_d;
            s1_any_q  <= s1_any_d;
            s2_vld_q  <= s2_vld_d;
            s2_data_q <= s2_data_d;
            sat_q     <= sat_d;
        end
    end

    // Each ready depends only on the other stream's valid, never its own.
    assign oReady_AM_Accum2 = iValid_AM_Activ  & w_s1_can_load;
    assign oReady_AM_Activ  = iValid_AM_Accum2 & w_s1_can_load;
    assign oValid_BM_Delta1 = s2_vld_q;
    assign oData_BM_Delta1  = s2_data_q;
    assign oSat             = sat_q;

endmodule

`default_nettype wire

// File: tb/tb_backward_delta.sv
// ============================================================================
//  Module      : tb_backward_delta
//  Description : Self-checking bench for backward_delta. Two instances:
//                u0 (SHIFT=0, BURST="yes") and u1 (SHIFT=2, BURST="no").
//                A queue-level reference model predicts readies, output
//                valid/data and the sticky saturation flag every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_backward_delta;

    localparam int NN = 7;
    localparam int NC = 11;
    localparam int WF = 5;
    localparam int WA = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] va  = '0;
    logic [1:0] vb  = '0;
    logic [1:0] rdy = 2'b11;
    logic [NC*WA-1:0] acc0 = '0, acc1 = '0;
    logic [NC*WF-1:0] act0 = '0, act1 = '0;
    logic [1:0] ordA, ordB, oval, osat;
    logic [NC*WF-1:0] od0, od1;

    backward_delta #(.NN(NN), .NC(NC), .WF(WF), .SHIFT(0), .BURST("yes")) u0 (
        .iCLK(clk), .iRST(rst),
        .iValid_AM_Accum2(va[0]), .oReady_AM_Accum2(ordA[0]), .iData_AM_Accum2(acc0),
        .iValid_AM_Activ(vb[0]),  .oReady_AM_Activ(ordB[0]),  .iData_AM_Activ(act0),
        .oValid_BM_Delta1(oval[0]), .iReady_BM_Delta1(rdy[0]), .oData_BM_Delta1(od0),
        .oSat(osat[0])
    );

    backward_delta #(.NN(NN), .NC(NC), .WF(WF), .SHIFT(2), .BURST("no")) u1 (
        .iCLK(clk), .iRST(rst),
        .iValid_AM_Accum2(va[1]), .oReady_AM_Accum2(ordA[1]), .iData_AM_Accum2(acc1),
        .iValid_AM_Activ(vb[1]),  .oReady_AM_Activ(ordB[1]),  .iData_AM_Activ(act1),
        .oValid_BM_Delta1(oval[1]), .iReady_BM_Delta1(rdy[1]), .oData_BM_Delta1(od1),
        .oSat(osat[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at t=%0t", nm, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: plain integer arithmetic per lane
    // ------------------------------------------------------------------
    function automatic logic [WF-1:0] lane_ref(input int accum, input int act, input int sh,
                                               output bit s);
        int t;
        int r;
        t = accum >>> sh;
        r = t;
        if (t > 15)  r = 15;
        if (t < -16) r = -16;
        s = (r != t);
        if (act <= 0) r = 0;
        return r[WF-1:0];
    endfunction

    function automatic logic [NC*WF-1:0] vec_ref(input logic [NC*WA-1:0] a,
                                                 input logic [NC*WF-1:0] b,
                                                 input int sh, output bit anys);
        logic [NC*WF-1:0] r;
        bit s;
        r = '0;
        anys = 1'b0;
        for (int k = 0; k < NC; k++) begin
            r[k*WF +: WF] = lane_ref(int'($signed(a[k*WA +: WA])),
                                     int'($signed(b[k*WF +: WF])), sh, s);
            anys |= s;
        end
        return r;
    endfunction

    typedef struct {
        logic [NC*WF-1:0] d;
        bit               s;
        int               acc;
        bit               cnt;
    } item_t;

    item_t mq [2][4];
    int    mh [2] = '{0, 0};
    int    mn [2] = '{0, 0};
    bit    sat_exp [2] = '{0, 0};
    int    acc_cnt [2] = '{0, 0};
    int    out_cnt [2] = '{0, 0};
    int    cyc = 0;
    bit    init_done = 1'b0;

    // One cycle of prediction and comparison for instance i. Items accepted
    // in cycle n are visible from cycle n+2 once they reach the queue head.
    task automatic mon(input int i);
        logic v_a, v_b, r, ov, ra, rb, os;
        logic [NC*WF-1:0] d, b;
        logic [NC*WA-1:0] a;
        int    sh, n, slot;
        bit    burst, ev, can, s;
        item_t h;
        v_a = va[i]; v_b = vb[i]; r = rdy[i]; ov = oval[i];
        ra = ordA[i]; rb = ordB[i]; os = osat[i];
        d  = (i == 0) ? od0  : od1;
        a  = (i == 0) ? acc0 : acc1;
        b  = (i == 0) ? act0 : act1;
        sh = (i == 0) ? 0 : 2;
        burst = (i == 0);
        n  = mn[i];
        h  = mq[i][mh[i]];
        ev = (n > 0) && (cyc >= h.acc + 2);
        if (ev && !h.cnt) begin
            sat_exp[i] |= h.s;
            mq[i][mh[i]].cnt = 1'b1;
        end
        chk($sformatf("u%0d oValid", i), ov, ev);
        if (ev) chk($sformatf("u%0d oData", i), d, h.d);
        chk($sformatf("u%0d oSat", i), os, sat_exp[i]);
        can = burst ? ((n < 2) || r) : (n == 0);
        chk($sformatf("u%0d readyAccum", i), ra, v_b & can);
        chk($sformatf("u%0d readyActiv", i), rb, v_a & can);
        if (rst) begin
            mn[i] = 0; mh[i] = 0; sat_exp[i] = 1'b0;
        end else begin
            if (ev && r) begin
                mh[i] = (mh[i] + 1) % 4;
                mn[i]--;
                out_cnt[i]++;
            end
            if (v_a && v_b && can) begin
                slot = (mh[i] + mn[i]) % 4;
                mq[i][slot].d   = vec_ref(a, b, sh, s);
                mq[i][slot].s   = s;
                mq[i][slot].acc = cyc;
                mq[i][slot].cnt = 1'b0;
                mn[i]++;
                acc_cnt[i]++;
            end
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!init_done) begin
            if (rst) init_done = 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) mon(i);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic set_data(input int i, input logic [NC*WA-1:0] a, input logic [NC*WF-1:0] b);
        if (i == 0) begin acc0 = a; act0 = b; end
        else        begin acc1 = a; act1 = b; end
    endtask

    // Present one joined vector on instance i and hold it until accepted.
    task automatic pulse(input int i, input logic [NC*WA-1:0] a, input logic [NC*WF-1:0] b);
        bit got;
        got = 1'b0;
        set_data(i, a, b);
        va[i] = 1'b1; vb[i] = 1'b1;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            got = ordA[i] & ordB[i];
            @(posedge clk); #1;
        end
        chk($sformatf("u%0d handshake", i), got, 1'b1);
        va[i] = 1'b0; vb[i] = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [NC*WA-1:0] rand_acc();
        logic [NC*WA-1:0] r;
        for (int k = 0; k < NC; k++) begin
            case ($urandom_range(0, 3))
                0: r[k*WA +: WA] = 8'($urandom);
                1: r[k*WA +: WA] = 8'h80;
                2: r[k*WA +: WA] = 8'h7F;
                default: r[k*WA +: WA] = 8'($urandom_range(0, 40) - 20);
            endcase
        end
        return r;
    endfunction

    function automatic logic [NC*WF-1:0] rand_act();
        logic [NC*WF-1:0] r;
        for (int k = 0; k < NC; k++) r[k*WF +: WF] = 5'($urandom);
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    logic [NC*WA-1:0] a_v;
    logic [NC*WF-1:0] b_v;
    int base;
    bit sd;

    initial begin
        // Pin the reference model against hand-computed values.
        chk("ref 9/3",      lane_ref(9, 3, 0, sd),    5'd9);
        chk("ref 100/1",    lane_ref(100, 1, 0, sd),  5'd15);
        chk("ref sat flag", sd, 1'b1);
        chk("ref -20/1",    lane_ref(-20, 1, 0, sd),  5'h10);
        chk("ref -128/1",   lane_ref(-128, 1, 0, sd), 5'h10);
        chk("ref act0",     lane_ref(9, 0, 0, sd),    5'd0);
        chk("ref actneg",   lane_ref(9, -2, 0, sd),   5'd0);
        chk("ref sh2 -7",   lane_ref(-7, 1, 2, sd),   5'h1E);

        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        @(negedge clk);
        chk("reset oValid", oval, 2'b00);
        chk("reset oSat",   osat, 2'b00);
        chk("reset oData",  od0, '0);
        cycles(1);

        // 1: lane0 accum 9, act 3
        a_v = '0; b_v = '0;
        a_v[7:0] = 8'd9; b_v[4:0] = 5'd3;
        pulse(0, a_v, b_v);
        @(negedge clk);
        chk("t1 early valid", oval[0], 1'b0);
        @(negedge clk);
        chk("t1 valid", oval[0], 1'b1);
        chk("t1 lane0", od0[4:0], 5'd9);
        chk("t1 oSat", osat[0], 1'b0);
        cycles(2);

        // 2: saturation both directions, oSat sticky
        a_v = '0; b_v = '0;
        a_v[7:0] = 8'd100; a_v[15:8] = 8'hEC; a_v[23:16] = 8'h80;
        for (int k = 0; k < NC; k++) b_v[k*WF +: WF] = 5'd1;
        pulse(0, a_v, b_v);
        @(negedge clk);
        @(negedge clk);
        chk("t2 lane0", od0[4:0],   5'd15);
        chk("t2 lane1", od0[9:5],   5'h10);
        chk("t2 lane2", od0[14:10], 5'h10);
        chk("t2 oSat",  osat[0], 1'b1);
        cycles(2);

        // 3: mask by zero / negative activation; SHIFT=2 on u1
        a_v = '0; b_v = '0;
        a_v[7:0] = 8'd9; a_v[15:8] = 8'd9; b_v[9:5] = 5'h1E;
        pulse(0, a_v, b_v);
        @(negedge clk);
        @(negedge clk);
        chk("t3 lane0 masked", od0[4:0], 5'd0);
        chk("t3 lane1 masked", od0[9:5], 5'd0);
        chk("t3 oSat sticky", osat[0], 1'b1);
        a_v = '0; b_v = '0;
        a_v[7:0] = 8'hF9; b_v[4:0] = 5'd1;
        pulse(1, a_v, b_v);
        @(negedge clk);
        @(negedge clk);
        chk("t3 shift lane0", od1[4:0], 5'h1E);
        cycles(2);

        // 4: accum valid alone -> no ready, no output; then a single transfer
        base = out_cnt[0];
        set_data(0, rand_acc(), rand_act());
        va[0] = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            chk("t4 no ready", ordA[0], 1'b0);
            chk("t4 no output", oval[0], 1'b0);
            @(posedge clk); #1;
        end
        pulse(0, acc0, act0);
        cycles(6);
        chk("t4 one output", out_cnt[0] - base, 1);

        // 5: six back-to-back vectors with an output stall
        base = out_cnt[0];
        fork
            begin
                for (int j = 0; j < 6; j++) begin
                    a_v = '0; b_v = '0;
                    a_v[7:0] = 8'(j + 1); b_v[4:0] = 5'd1;
                    pulse(0, a_v, b_v);
                end
            end
            begin
                cycles(3);
                rdy[0] = 1'b0;
                cycles(3);
                rdy[0] = 1'b1;
            end
        join
        cycles(6);
        chk("t5 six outputs", out_cnt[0] - base, 6);

        // 6: non-burst instance accepts every third cycle
        base = acc_cnt[1];
        set_data(1, rand_acc(), rand_act());
        va[1] = 1'b1; vb[1] = 1'b1;
        cycles(12);
        va[1] = 1'b0; vb[1] = 1'b0;
        chk("t6 accept rate", acc_cnt[1] - base, 4);
        cycles(4);

        // Reset with both stages of u0 full and stalled
        rdy[0] = 1'b0;
        a_v = '0; b_v = '0; a_v[7:0] = 8'd100; b_v[4:0] = 5'd1;
        pulse(0, a_v, b_v);
        pulse(0, a_v, b_v);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        rdy[0] = 1'b1;
        @(negedge clk);
        chk("t6 reset oValid", oval[0], 1'b0);
        chk("t6 reset oSat", osat[0], 1'b0);
        a_v = '0; b_v = '0; a_v[7:0] = 8'd9; b_v[4:0] = 5'd3;
        cycles(1);
        pulse(0, a_v, b_v);
        @(negedge clk);
        @(negedge clk);
        chk("t6 after reset valid", oval[0], 1'b1);
        chk("t6 after reset lane0", od0[4:0], 5'd9);
        cycles(2);

        // Randomized traffic on both instances
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < 2; i++) begin
                va[i]  = ($urandom_range(0, 3) != 0);
                vb[i]  = ($urandom_range(0, 3) != 0);
                rdy[i] = ($urandom_range(0, 3) != 0);
                set_data(i, rand_acc(), rand_act());
            end
            rst = ($urandom_range(0, 299) == 0);
            cycles(1);
        end
        rst = 1'b0;
        va = '0; vb = '0; rdy = 2'b11;
        cycles(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
